// File: rtl/bus_xfer_ctrl_if.sv
// Command handshake and tristate bus control bundle for bus_xfer_ctrl.
// master drives commands in; slave is the sequencer that produces strobes and status.
interface bus_xfer_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_src;
  logic [3:0]  cmd_dst;
  logic [4:1]  l;
  logic [4:1]  en;
  logic        done;
  logic        err;
  logic        busy;
  logic [15:0] xfer_count;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    input  cmd_ready, l, en, done, err, busy, xfer_count
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    output cmd_ready, l, en, done, err, busy, xfer_count
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Tristate register-bus transfer sequencer: accept -> DRIVE/LOAD/RELEASE (done in cycle 3), reject -> err in cycle 1.
// cmd_ready only in IDLE (one transfer per 4 cycles); BUS_XFER_COUNT_EN builds the completed-transfer counter.
module bus_xfer_ctrl (
  input logic            clk,
  input logic            rst,
  bus_xfer_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DRIVE   = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] REJECT  = 3'd4;

  logic [2:0] state;
  logic [3:0] dst_q;
  logic [3:0] l_q;
  logic [3:0] en_q;
  logic       done_q;
  logic       err_q;
  logic       cmd_ok;
  logic [3:0] src_en_n;

  // A transfer must write somewhere and must never reload its own source.
  assign cmd_ok   = (bus.cmd_dst != 4'b0000) && !bus.cmd_dst[bus.cmd_src];
  assign src_en_n = ~(4'b0001 << bus.cmd_src);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dst_q  <= 4'b0000;
      l_q    <= 4'hF;
      en_q   <= 4'hF;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            dst_q <= bus.cmd_dst;
            if (cmd_ok) begin
              state <= DRIVE;
              en_q  <= src_en_n;
            end else begin
              state <= REJECT;
              err_q <= 1'b1;
            end
          end
        end
        DRIVE: begin
          state <= LOAD;
          l_q   <= ~dst_q;
        end
        LOAD: begin
          state  <= RELEASE;
          l_q    <= 4'hF;
          en_q   <= 4'hF;
          done_q <= 1'b1;
        end
        RELEASE: state <= IDLE;
        REJECT:  state <= IDLE;
        default: begin
          state <= IDLE;
          l_q   <= 4'hF;
          en_q  <= 4'hF;
        end
      endcase
    end
  end

  assign bus.l         = l_q;
  assign bus.en        = en_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

`ifdef BUS_XFER_COUNT_EN
  logic [15:0] count_q;

  // Bumped on the LOAD->RELEASE edge so the new value is visible alongside done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else if (state == LOAD) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign bus.xfer_count = count_q;
`else
  assign bus.xfer_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: vector table of single commands plus back-to-back, mid-transfer reset and counter sequences.
module tb_bus_xfer_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total   = 0;
  int   bad     = 0;
  int   exp_cnt = 0;
  logic mon_on  = 1'b0;

  always #5 clk = ~clk;

  bus_xfer_ctrl_if bus ();

  bus_xfer_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] src;
    logic [3:0] dst;
    logic       ok;
    logic [3:0] en_drv;
    logic [3:0] l_ld;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp();
`ifdef BUS_XFER_COUNT_EN
    return exp_cnt[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  // Bus-safety invariants, sampled every cycle once reset is released.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      check("inv_one_driver", 16'($countones(~bus.en) <= 1), 16'd1);
      if (bus.l != 4'hF)
        check("inv_load_needs_driver", 16'($countones(~bus.en)), 16'd1);
    end
  end

  task automatic run_cmd(input logic [1:0] src, input logic [3:0] dst, input logic ok,
                         input logic [3:0] en_drv, input logic [3:0] l_ld, input string tag);
    @(negedge clk);
    check({tag, "_ready"}, 16'(bus.cmd_ready), 16'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (ok) begin
      check({tag, "_c1_en"}, 16'(bus.en), 16'(en_drv));
      check({tag, "_c1_l"}, 16'(bus.l), 16'hF);
      check({tag, "_c1_busy"}, 16'(bus.busy), 16'd1);
      @(negedge clk);
      check({tag, "_c2_en"}, 16'(bus.en), 16'(en_drv));
      check({tag, "_c2_l"}, 16'(bus.l), 16'(l_ld));
      @(negedge clk);
      exp_cnt++;
      check({tag, "_c3_done"}, 16'(bus.done), 16'd1);
      check({tag, "_c3_enl"}, {8'h0, bus.en, bus.l}, 16'h00FF);
      check({tag, "_c3_count"}, bus.xfer_count, cnt_exp());
    end else begin
      check({tag, "_c1_err"}, 16'(bus.err), 16'd1);
      check({tag, "_c1_enl"}, {8'h0, bus.en, bus.l}, 16'h00FF);
      check({tag, "_c1_done"}, 16'(bus.done), 16'd0);
    end
    @(negedge clk);
    check({tag, "_end_ready"}, 16'(bus.cmd_ready), 16'd1);
    check({tag, "_end_pulses"}, {14'h0, bus.done, bus.err}, 16'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = 2'd0;
    bus.cmd_dst   = 4'd0;

    vecs[0] = '{2'd2, 4'b0001, 1'b1, 4'b1011, 4'b1110};
    vecs[1] = '{2'd0, 4'b0110, 1'b1, 4'b1110, 4'b1001};
    vecs[2] = '{2'd1, 4'b0010, 1'b0, 4'hF,    4'hF};
    vecs[3] = '{2'd3, 4'b0111, 1'b1, 4'b0111, 4'b1000};
    vecs[4] = '{2'd3, 4'b0000, 1'b0, 4'hF,    4'hF};
    vecs[5] = '{2'd1, 4'b1101, 1'b1, 4'b1101, 4'b0010};
    vecs[6] = '{2'd0, 4'b0001, 1'b0, 4'hF,    4'hF};

    repeat (2) @(negedge clk);
    check("rst_l", 16'(bus.l), 16'hF);
    check("rst_en", 16'(bus.en), 16'hF);
    check("rst_ready", 16'(bus.cmd_ready), 16'd1);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_pulses", {14'h0, bus.done, bus.err}, 16'd0);
    check("rst_count", bus.xfer_count, 16'h0000);
    rst    = 1'b0;
    mon_on = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].src, vecs[i].dst, vecs[i].ok, vecs[i].en_drv, vecs[i].l_ld,
              $sformatf("v%0d", i));
      if (i == 3) begin
`ifdef BUS_XFER_COUNT_EN
        check("count_3ok_1rej", bus.xfer_count, 16'd3);
`else
        check("count_off", bus.xfer_count, 16'd0);
`endif
      end
    end

    // Back-to-back: second command waits behind the first while valid stays high.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = 2'd0;
    bus.cmd_dst   = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    check("b2b_c1_en", 16'(bus.en), 16'b1110);
    bus.cmd_src = 2'd3;
    bus.cmd_dst = 4'b0001;
    @(negedge clk);
    check("b2b_c2_l", 16'(bus.l), 16'b1001);
    @(negedge clk);
    exp_cnt++;
    check("b2b_c3_done", 16'(bus.done), 16'd1);
    @(negedge clk);
    check("b2b_c4_ready", 16'(bus.cmd_ready), 16'd1);
    check("b2b_c4_dead", {8'h0, bus.en, bus.l}, 16'h00FF);
    @(negedge clk);
    check("b2b_c5_en", 16'(bus.en), 16'b0111);
    check("b2b_c5_busy", 16'(bus.busy), 16'd1);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_c6_l", 16'(bus.l), 16'b1110);
    @(negedge clk);
    exp_cnt++;
    check("b2b_c7_done", 16'(bus.done), 16'd1);
    check("b2b_c7_count", bus.xfer_count, cnt_exp());
    @(negedge clk);
    check("b2b_c8_ready", 16'(bus.cmd_ready), 16'd1);

    // Reset during LOAD drops the transfer; a command waiting at release is taken on the first edge.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = 2'd1;
    bus.cmd_dst   = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("mrst_c1_en", 16'(bus.en), 16'b1101);
    @(negedge clk);
    check("mrst_c2_l", 16'(bus.l), 16'b1110);
    #2 rst = 1'b1;
    #1;
    check("mrst_async_enl", {8'h0, bus.en, bus.l}, 16'h00FF);
    check("mrst_async_busy", 16'(bus.busy), 16'd0);
    exp_cnt = 0;
    @(negedge clk);
    check("mrst_no_done", 16'(bus.done), 16'd0);
    check("mrst_count", bus.xfer_count, 16'h0000);
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = 2'd0;
    bus.cmd_dst   = 4'b1000;
    rst           = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("rel_c1_en", 16'(bus.en), 16'b1110);
    check("rel_c1_done", 16'(bus.done), 16'd0);
    @(negedge clk);
    check("rel_c2_l", 16'(bus.l), 16'b0111);
    @(negedge clk);
    exp_cnt++;
    check("rel_c3_done", 16'(bus.done), 16'd1);
    check("rel_c3_count", bus.xfer_count, cnt_exp());
    @(negedge clk);

`ifdef BUS_XFER_COUNT_EN
    @(negedge clk);
    dut.count_q = 16'hFFFF;
    exp_cnt     = 16'hFFFF;
    run_cmd(2'd3, 4'b0001, 1'b1, 4'b0111, 4'b1110, "wrap");
    check("wrap_count", bus.xfer_count, 16'h0000);
`else
    check("count_off_end", bus.xfer_count, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
